// File: rtl/rf_bypass.sv
// Register-file bypass and load-use interlock for a five-stage pipeline.
// Keeps destination tags for the EX, MEM and WB stages and forwards the
// youngest in-flight result to both ID operands. It stalls ID for one cycle
// when an operand depends on a load that is still in EX, and it drives the
// register-file write port from the WB stage.
module rf_bypass (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RNUM1,
  input  logic [4:0]  RNUM2,
  input  logic        RUSE1,
  input  logic        RUSE2,
  input  logic [31:0] RFDATA1,
  input  logic [31:0] RFDATA2,
  input  logic        ID_VALID,
  input  logic [4:0]  ID_WNUM,
  input  logic        ID_LOAD,
  input  logic        FLUSH,
  input  logic [31:0] EX_RESULT,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] OP1,
  output logic [31:0] OP2,
  output logic        STALL,
  output logic [4:0]  WNUM,
  output logic [31:0] WDATA
);

  // EX stage tag. Data is not stored here because EX_RESULT is live.
  logic        r_ex_valid;
  logic [4:0]  r_ex_wnum;
  logic        r_ex_load;

  // MEM stage tag and ALU result captured from EX.
  logic        r_mem_valid;
  logic [4:0]  r_mem_wnum;
  logic        r_mem_load;
  logic [31:0] r_mem_data;

  // WB stage. The load/ALU choice is made on entry, so WB needs no load flag.
  logic        r_wb_valid;
  logic [4:0]  r_wb_wnum;
  logic [31:0] r_wb_data;

  logic        w_stall;
  logic        w_ex_bypass1;
  logic        w_ex_bypass2;
  logic        w_mem_hit1;
  logic        w_mem_hit2;
  logic        w_wb_hit1;
  logic        w_wb_hit2;
  logic [31:0] w_mem_value;

  // A destination of x0 never writes, so it cannot create a load-use hazard.
  // A taken branch kills the dependent ID instruction, so FLUSH suppresses the stall.
  assign w_stall = ~FLUSH & r_ex_valid & r_ex_load & (r_ex_wnum != 5'd0) &
                   ((RUSE1 & (RNUM1 == r_ex_wnum)) | (RUSE2 & (RNUM2 == r_ex_wnum)));

  // The value a MEM-stage instruction will write: load data or its captured ALU result.
  assign w_mem_value = r_mem_load ? MEM_RDATA : r_mem_data;

  // Match terms. RNUMn==0 is handled first in the operand mux, so a match here
  // already implies a non-zero destination.
  assign w_ex_bypass1 = r_ex_valid & ~r_ex_load & (r_ex_wnum == RNUM1);
  assign w_ex_bypass2 = r_ex_valid & ~r_ex_load & (r_ex_wnum == RNUM2);
  assign w_mem_hit1   = r_mem_valid & (r_mem_wnum == RNUM1);
  assign w_mem_hit2   = r_mem_valid & (r_mem_wnum == RNUM2);
  assign w_wb_hit1    = r_wb_valid & (r_wb_wnum == RNUM1);
  assign w_wb_hit2    = r_wb_valid & (r_wb_wnum == RNUM2);

  // EX tag: take the ID instruction, or insert a bubble on invalid/stall/flush.
  // NOTE: clocked state uses non-blocking assignments so that every stage samples the pre-edge values of the stage before it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ex_valid <= 1'b0;
      r_ex_wnum  <= 5'd0;
      r_ex_load  <= 1'b0;
    end else begin
      r_ex_valid <= ID_VALID & ~w_stall & ~FLUSH;
      r_ex_wnum  <= ID_WNUM;
      r_ex_load  <= ID_LOAD;
    end
  end

  // MEM tag and data. For an EX load the captured EX_RESULT is unused.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mem_valid <= 1'b0;
      r_mem_wnum  <= 5'd0;
      r_mem_load  <= 1'b0;
      r_mem_data  <= 32'd0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_wnum  <= r_ex_wnum;
      r_mem_load  <= r_ex_load;
      r_mem_data  <= EX_RESULT;
    end
  end

  // WB tag and final write data. Reset clears the valid bit, so in-flight
  // results are never written after reset is released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wb_valid <= 1'b0;
      r_wb_wnum  <= 5'd0;
      r_wb_data  <= 32'd0;
    end else begin
      r_wb_valid <= r_mem_valid;
      r_wb_wnum  <= r_mem_wnum;
      r_wb_data  <= w_mem_value;
    end
  end

  // Operand 1 priority: x0, then EX (non-load), then MEM, then WB, then the rf.
  // NOTE: each output gets a default first, so no path through the mux can infer a latch.
  always_comb begin
    OP1 = RFDATA1;
    if (RNUM1 == 5'd0)     OP1 = 32'd0;
    else if (w_ex_bypass1) OP1 = EX_RESULT;
    else if (w_mem_hit1)   OP1 = w_mem_value;
    else if (w_wb_hit1)    OP1 = r_wb_data;
  end

  // Operand 2 priority: identical to operand 1.
  always_comb begin
    OP2 = RFDATA2;
    if (RNUM2 == 5'd0)     OP2 = 32'd0;
    else if (w_ex_bypass2) OP2 = EX_RESULT;
    else if (w_mem_hit2)   OP2 = w_mem_value;
    else if (w_wb_hit2)    OP2 = r_wb_data;
  end

  // Write port and stall output. WNUM=0 means no rf write this cycle.
  always_comb begin
    STALL = w_stall;
    WNUM  = r_wb_valid ? r_wb_wnum : 5'd0;
    WDATA = r_wb_data;
  end

endmodule

// File: tb/tb_rf_bypass.sv
// Testbench for rf_bypass. An instruction-level reference model records each
// issued instruction's destination and the value it produces. The driver
// pushes the expected outputs for each cycle into a queue, and a monitor pops
// and compares them on the falling edge.
module tb_rf_bypass;

  logic        CLK;
  logic        RST;
  logic [4:0]  RNUM1;
  logic [4:0]  RNUM2;
  logic        RUSE1;
  logic        RUSE2;
  logic [31:0] RFDATA1;
  logic [31:0] RFDATA2;
  logic        ID_VALID;
  logic [4:0]  ID_WNUM;
  logic        ID_LOAD;
  logic        FLUSH;
  logic [31:0] EX_RESULT;
  logic [31:0] MEM_RDATA;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic        STALL;
  logic [4:0]  WNUM;
  logic [31:0] WDATA;

  rf_bypass dut (
    .CLK(CLK), .RST(RST),
    .RNUM1(RNUM1), .RNUM2(RNUM2), .RUSE1(RUSE1), .RUSE2(RUSE2),
    .RFDATA1(RFDATA1), .RFDATA2(RFDATA2),
    .ID_VALID(ID_VALID), .ID_WNUM(ID_WNUM), .ID_LOAD(ID_LOAD),
    .FLUSH(FLUSH), .EX_RESULT(EX_RESULT), .MEM_RDATA(MEM_RDATA),
    .OP1(OP1), .OP2(OP2), .STALL(STALL), .WNUM(WNUM), .WDATA(WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One in-flight instruction. Index 0 is the one in EX, index 1 is in MEM,
  // and index 2 is in WB. "known" means the value it will write is defined.
  typedef struct {
    bit          valid;
    logic [4:0]  wnum;
    bit          load;
    logic [31:0] val;
    bit          known;
  } slot_t;

  typedef struct {
    logic        stall;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    bit          chk_wdata;
  } exp_t;

  slot_t pipe [3];
  exp_t  exp_q [$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{valid: 1'b0, wnum: 5'd0, load: 1'b0, val: 32'd0, known: 1'b1};
  endfunction

  // Value an ID operand should see: the youngest valid producer of that register.
  // A load still in EX has no value yet.
  function automatic logic [31:0] model_op(input logic [4:0] rnum, input logic [31:0] rf);
    if (rnum == 5'd0) return 32'd0;
    if (pipe[0].valid && pipe[0].wnum == rnum && !pipe[0].load) return EX_RESULT;
    if (pipe[1].valid && pipe[1].wnum == rnum) return pipe[1].load ? MEM_RDATA : pipe[1].val;
    if (pipe[2].valid && pipe[2].wnum == rnum) return pipe[2].val;
    return rf;
  endfunction

  function automatic bit model_stall();
    if (FLUSH || !pipe[0].valid || !pipe[0].load || pipe[0].wnum == 5'd0) return 1'b0;
    return (RUSE1 && RNUM1 == pipe[0].wnum) || (RUSE2 && RNUM2 == pipe[0].wnum);
  endfunction

  task automatic drive(input bit v, input logic [4:0] wn, input bit ld,
                       input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                       input bit fl, input logic [31:0] exr, input logic [31:0] mrd);
    ID_VALID = v; ID_WNUM = wn; ID_LOAD = ld;
    RNUM1 = r1; RUSE1 = u1; RNUM2 = r2; RUSE2 = u2;
    FLUSH = fl; EX_RESULT = exr; MEM_RDATA = mrd;
    RFDATA1 = $urandom; RFDATA2 = $urandom;
  endtask

  // Push this cycle's expectations, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    bit   st;
    bit   acc;
    st = model_stall();
    e.stall     = st;
    e.op1       = model_op(RNUM1, RFDATA1);
    e.op2       = model_op(RNUM2, RFDATA2);
    e.wnum      = pipe[2].valid ? pipe[2].wnum : 5'd0;
    e.wdata     = pipe[2].val;
    e.chk_wdata = pipe[2].known;
    exp_q.push_back(e);
    @(posedge CLK);
    if (!pipe[0].load) pipe[0].val = EX_RESULT;
    if (pipe[1].load)  pipe[1].val = MEM_RDATA;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    acc = ID_VALID && !st && !FLUSH;
    pipe[0] = '{valid: acc, wnum: ID_WNUM, load: ID_LOAD, val: 32'd0, known: acc};
    #1;
  endtask

  task automatic idle();
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom);
  endtask

  // Entered 1 time unit after a rising edge. Asserts reset mid-cycle and holds it
  // across one edge. Control returns 1 time unit after the following rising edge.
  task automatic do_reset();
    #6;
    RST = 1'b1;
    ID_VALID = 1'b0;
    #1;
    check("rst_wnum", {27'd0, WNUM}, 32'd0);
    check("rst_wdata", WDATA, 32'd0);
    check("rst_stall", {31'd0, STALL}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: compare on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (!RST && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sb_stall", {31'd0, STALL}, {31'd0, mon_e.stall});
      check("sb_op1", OP1, mon_e.op1);
      check("sb_op2", OP2, mon_e.op2);
      check("sb_wnum", {27'd0, WNUM}, {27'd0, mon_e.wnum});
      if (mon_e.chk_wdata) check("sb_wdata", WDATA, mon_e.wdata);
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    RST = 1'b1;
    model_reset();
    drive(0, 5'd0, 0, 5'd3, 1, 5'd0, 1, 0, 32'd0, 32'd0);
    RFDATA2 = 32'hFFFF_FFFF;
    #3;
    check("reset_wnum", {27'd0, WNUM}, 32'd0);
    check("reset_wdata", WDATA, 32'd0);
    check("reset_stall", {31'd0, STALL}, 32'd0);
    check("reset_op1_rf", OP1, RFDATA1);
    check("reset_op2_x0", OP2, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Back-to-back ALU: x5 = 0x11 is forwarded from EX, then from MEM, then from WB.
    drive(1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(0, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 32'h11, $urandom); #1;
    check("b2b_ex", OP1, 32'h11); step();
    drive(0, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, $urandom, $urandom); #1;
    check("b2b_mem", OP1, 32'h11); step();
    drive(0, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, $urandom, $urandom); #1;
    check("b2b_wb", OP1, 32'h11);
    check("b2b_wnum", {27'd0, WNUM}, 32'd5);
    check("b2b_wdata", WDATA, 32'h11); step();

    // Load-use: exactly one stall cycle, then the operand comes from MEM_RDATA.
    drive(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(1, 5'd8, 0, 5'd0, 0, 5'd7, 1, 0, $urandom, $urandom); #1;
    check("lu_stall", {31'd0, STALL}, 32'd1); step();
    drive(1, 5'd8, 0, 5'd0, 0, 5'd7, 1, 0, $urandom, 32'hDEADBEEF); #1;
    check("lu_nostall", {31'd0, STALL}, 32'd0);
    check("lu_op2", OP2, 32'hDEADBEEF); step();

    // Priority: the youngest writer of x3 wins. An unused operand never stalls.
    drive(1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 0, 32'hC, $urandom); step();
    drive(1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 0, 32'hB, $urandom); step();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 32'hA, $urandom); #1;
    check("prio_ex", OP1, 32'hA); step();
    drive(1, 5'd4, 0, 5'd3, 0, 5'd0, 0, 0, $urandom, $urandom); #1;
    check("prio_nouse_stall", {31'd0, STALL}, 32'd0); step();

    // x0: never forwarded and never written.
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 32'h55, $urandom); #1;
    check("x0_op1", OP1, 32'd0);
    check("x0_stall", {31'd0, STALL}, 32'd0); step();
    idle(); step();
    idle(); #1;
    check("x0_wnum", {27'd0, WNUM}, 32'd0); step();

    // FLUSH with a load-use hazard present: no stall, and the killed slot never writes.
    drive(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(1, 5'd10, 0, 5'd9, 1, 5'd0, 0, 1, $urandom, $urandom); #1;
    check("flush_stall", {31'd0, STALL}, 32'd0); step();
    idle(); step();
    idle(); step();
    idle(); #1;
    check("flush_wnum", {27'd0, WNUM}, 32'd0); step();

    // Reset with three valid stages: nothing in flight is written after release.
    drive(1, 5'd1, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    drive(1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 0, $urandom, $urandom); step();
    idle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); #1;
      check("post_rst_wnum", {27'd0, WNUM}, 32'd0); step();
    end

    // Randomized traffic over a small register window so that matches are frequent.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 9) == 0), $urandom, $urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    idle(); step();
    #5;
    check("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
